// File: rtl/mult_feed_pkg.sv
// Shared sizes, index type and FSM states for the 15-tap product feeder.
package mult_feed_pkg;
  localparam int N_TAPS = 15;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;
  localparam int PROD_W = 32;
  localparam int IDX_W  = 4;
  localparam int RAW_W  = PIX_W + 1 + COEF_W;  // signed(zext pixel) * coef

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = 4'd14;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  function automatic logic [PROD_W-1:0] sext_prod(input logic signed [RAW_W-1:0] p);
    return {{(PROD_W-RAW_W){p[RAW_W-1]}}, p};
  endfunction
endpackage

// File: rtl/mult_feed_if.sv
// Window/coefficient/product bus of the feeder; slave = feeder, master = driver.
// mult_last and win_count exist only when MULT_FEED_LAST_EN is defined.
interface mult_feed_if;
  import mult_feed_pkg::*;
  logic                    win_valid;
  logic                    win_ready;
  logic [N_TAPS*PIX_W-1:0] win_data;
  logic                    coef_wr_en;
  idx_t                    coef_wr_addr;
  logic [COEF_W-1:0]       coef_wr_data;
  logic                    busy;
  logic                    mult_valid;
  logic [PROD_W-1:0]       mult_data;
`ifdef MULT_FEED_LAST_EN
  logic                    mult_last;
  logic [15:0]             win_count;
`endif

  modport slave (
    input  win_valid, win_data, coef_wr_en, coef_wr_addr, coef_wr_data,
`ifdef MULT_FEED_LAST_EN
    output mult_last, win_count,
`endif
    output win_ready, busy, mult_valid, mult_data
  );
  modport master (
    output win_valid, win_data, coef_wr_en, coef_wr_addr, coef_wr_data,
`ifdef MULT_FEED_LAST_EN
    input  mult_last, win_count,
`endif
    input  win_ready, busy, mult_valid, mult_data
  );
endinterface

// File: rtl/mult_feed_coef_rf.sv
// 15-entry signed coefficient file; writes are frozen while a window runs.
module mult_feed_coef_rf
  import mult_feed_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              busy_i,
  input  logic              wr_en_i,
  input  idx_t              wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
  input  idx_t              rd_idx_i,
  output logic [COEF_W-1:0] rd_data_o
);
  logic [N_TAPS-1:0][COEF_W-1:0] rf_q;
  logic                          wr_ok;

  assign wr_ok = wr_en_i && !busy_i && (wr_addr_i < idx_t'(N_TAPS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_q <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++)
        if (wr_ok && wr_addr_i == idx_t'(i)) rf_q[i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_idx_i < idx_t'(N_TAPS)) ? rf_q[rd_idx_i] : '0;
endmodule

// File: rtl/mult_feed15.sv
// Window-to-15-beat product feeder: one pixel*coef per cycle, gapless windows.
// Define MULT_FEED_LAST_EN for the mult_last / win_count outputs.
module mult_feed15
  import mult_feed_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  mult_feed_if.slave bus
);
  state_e                      state_q, state_d;
  idx_t                        idx_q, idx_d;
  logic [N_TAPS-1:0][PIX_W-1:0] win_q;
  logic                        run, at_last, accept;
  logic [COEF_W-1:0]           coef;
  logic signed [RAW_W-1:0]     prod;
  logic                        mult_valid_q;
  logic [PROD_W-1:0]           mult_data_q;

  assign run     = (state_q == ST_RUN);
  assign at_last = run && (idx_q == LAST_IDX);
  assign bus.win_ready = (state_q == ST_IDLE) || at_last;
  assign bus.busy      = run;
  assign accept  = bus.win_valid && bus.win_ready;

  mult_feed_coef_rf u_coef (
    .clk       (clk),
    .resetn    (resetn),
    .busy_i    (run),
    .wr_en_i   (bus.coef_wr_en),
    .wr_addr_i (bus.coef_wr_addr),
    .wr_data_i (bus.coef_wr_data),
    .rd_idx_i  (idx_q),
    .rd_data_o (coef)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_RUN;
        idx_d   = '0;
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (!accept) state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) win_q <= bus.win_data;
    end
  end

  // Pixel is unsigned: a zero MSB keeps it positive in the signed multiply.
  assign prod = $signed({1'b0, win_q[idx_q]}) * $signed(coef);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mult_valid_q <= 1'b0;
      mult_data_q  <= '0;
    end else begin
      mult_valid_q <= run;
      if (run) mult_data_q <= sext_prod(prod);
    end
  end

  assign bus.mult_valid = mult_valid_q;
  assign bus.mult_data  = mult_data_q;

`ifdef MULT_FEED_LAST_EN
  logic        last_q;
  logic [15:0] win_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q      <= 1'b0;
      win_count_q <= '0;
    end else begin
      last_q <= at_last;
      if (at_last) win_count_q <= win_count_q + 16'd1;
    end
  end

  assign bus.mult_last = last_q;
  assign bus.win_count = win_count_q;
`endif
endmodule

// File: tb/tb_mult_feed15.sv
// Directed bench for mult_feed15: beat trains, back-to-back windows, write gating, reset abort.
module tb_mult_feed15;
  import mult_feed_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mult_feed_if bus();
  mult_feed15 dut (.clk(clk), .resetn(resetn), .bus(bus));

  int errors = 0;
  int checks = 0;
  int coef_m [N_TAPS];
  int wins_m = 0;
  int sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [7:0] pv);
    for (int i = 0; i < N_TAPS; i++) bus.win_data[i*PIX_W +: PIX_W] = pv;
  endtask

  // Only used outside a running window, so in-range writes always land.
  task automatic wr_coef(input int a, input int d);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 4'(a);
    bus.coef_wr_data = 16'(d);
    tick();
    bus.coef_wr_en = 1'b0;
    if (a < N_TAPS) coef_m[a] = d;
  endtask

  task automatic run_win(input logic [7:0] pv, input bit midwr, input bit samewr, output int acc);
    logic [31:0] e;
    e = '0;
    acc = 0;
    set_win(pv);
    bus.win_valid = 1'b1;
    if (samewr) begin
      bus.coef_wr_en = 1'b1; bus.coef_wr_addr = 4'd0; bus.coef_wr_data = 16'd50;
    end
    chk("ready_idle", {31'd0, bus.win_ready}, 32'd1);
    tick();
    bus.win_valid = 1'b0;
    if (samewr) begin
      bus.coef_wr_en = 1'b0;
      coef_m[0] = 50;
    end
    chk("no_beat_at_accept", {31'd0, bus.mult_valid}, 32'd0);
    chk("busy_run", {31'd0, bus.busy}, 32'd1);
    for (int j = 0; j < N_TAPS; j++) begin
      if (midwr && j == 5) begin
        bus.coef_wr_en = 1'b1; bus.coef_wr_addr = 4'd3; bus.coef_wr_data = 16'd100;
      end
      tick();
      bus.coef_wr_en = 1'b0;
      e = 32'(int'(pv) * coef_m[j]);
      acc += int'(e);
      chk("beat_valid", {31'd0, bus.mult_valid}, 32'd1);
      chk("beat_data", bus.mult_data, e);
`ifdef MULT_FEED_LAST_EN
      chk("beat_last", {31'd0, bus.mult_last}, {31'd0, j == 14});
`endif
    end
    tick();
    chk("valid_after", {31'd0, bus.mult_valid}, 32'd0);
    chk("data_hold", bus.mult_data, e);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
`ifdef MULT_FEED_LAST_EN
    wins_m++;
    chk("win_count", {16'd0, bus.win_count}, 32'(wins_m & 16'hFFFF));
`endif
  endtask

  initial begin
    bus.win_valid = 1'b0; bus.win_data = '0;
    bus.coef_wr_en = 1'b0; bus.coef_wr_addr = '0; bus.coef_wr_data = '0;
    for (int i = 0; i < N_TAPS; i++) coef_m[i] = 0;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, bus.win_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_valid", {31'd0, bus.mult_valid}, 32'd0);
    chk("rst_data", bus.mult_data, 32'd0);
    @(negedge clk) resetn = 1'b1;
    tick();

    // Coef i+1, pixels 2 -> 2,4,...,30
    for (int i = 0; i < N_TAPS; i++) wr_coef(i, i + 1);
    run_win(8'd2, 1'b0, 1'b0, sum);

    // Extremes: 255*(-32768) and 255*32767
    wr_coef(0, -32768);
    wr_coef(1, 32767);
    run_win(8'd255, 1'b0, 1'b0, sum);

    // All -1, pixels 255 -> each 0xFFFFFF01, kernel sum 0xFFFFF10F
    for (int i = 0; i < N_TAPS; i++) wr_coef(i, -1);
    run_win(8'd255, 1'b0, 1'b0, sum);
    chk("acc_sum", 32'(sum), 32'hFFFF_F10F);

    // Three back-to-back windows with win_valid held high
    for (int i = 0; i < N_TAPS; i++) wr_coef(i, i + 1);
    set_win(8'd1);
    bus.win_valid = 1'b1;
    tick();
    set_win(8'd2);
    for (int c = 1; c <= 46; c++) begin
      tick();
      if (c <= 45) begin
        chk("b2b_valid", {31'd0, bus.mult_valid}, 32'd1);
        chk("b2b_data", bus.mult_data, 32'(((c - 1) % 15 + 1) * ((c - 1) / 15 + 1)));
`ifdef MULT_FEED_LAST_EN
        chk("b2b_last", {31'd0, bus.mult_last}, {31'd0, (c - 1) % 15 == 14});
`endif
      end else begin
        chk("b2b_valid_end", {31'd0, bus.mult_valid}, 32'd0);
      end
      chk("b2b_ready", {31'd0, bus.win_ready}, {31'd0, (c % 15 == 14) || c >= 45});
      if (c == 15) set_win(8'd3);
      if (c == 30) bus.win_valid = 1'b0;
    end
`ifdef MULT_FEED_LAST_EN
    wins_m += 3;
    chk("b2b_count", {16'd0, bus.win_count}, 32'(wins_m));
`endif

    // Write mid-RUN is dropped; next window still uses coef 3 = 4
    run_win(8'd1, 1'b1, 1'b0, sum);
    run_win(8'd1, 1'b0, 1'b0, sum);
    // Address 15 write in IDLE changes nothing
    wr_coef(15, 777);
    run_win(8'd1, 1'b0, 1'b0, sum);
    // Write alongside an IDLE handshake is used by that window
    run_win(8'd3, 1'b0, 1'b1, sum);

    // Reset at beat 7 aborts the train and clears coefs
    set_win(8'd3);
    bus.win_valid = 1'b1;
    tick();
    bus.win_valid = 1'b0;
    for (int j = 0; j <= 7; j++) begin
      tick();
      chk("pre_abort_data", bus.mult_data, 32'(3 * coef_m[j]));
    end
    resetn = 1'b0;
    #1;
    chk("abort_valid", {31'd0, bus.mult_valid}, 32'd0);
    chk("abort_data", bus.mult_data, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_ready", {31'd0, bus.win_ready}, 32'd1);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < N_TAPS; i++) coef_m[i] = 0;
    wins_m = 0;
    tick();
    run_win(8'd9, 1'b0, 1'b0, sum);
    chk("zero_sum", 32'(sum), 32'd0);
    run_win(8'd0, 1'b0, 1'b0, sum);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
